// File: rtl/ft_pkg.sv
// ft_pkg: shared types and constants for the checkpoint shadow register file.
//   NUM_REG       : number of architectural GPRs (2**FT_ADDR_WIDTH)
//   ckpt_entry_t  : one in-flight update {gv, addr, data, pv, pc}
//   BOOT_ADDR_DEF : default reset value of the checkpointed PC
package ft_pkg;

  localparam int FT_ADDR_WIDTH = 5;
  localparam int FT_DATA_WIDTH = 32;
  localparam int FT_PC_WIDTH   = 32;
  localparam int NUM_REG       = 2 ** FT_ADDR_WIDTH;

  localparam logic [FT_PC_WIDTH-1:0] BOOT_ADDR_DEF = 32'h0000_0080;

  typedef struct packed {
    logic                     gv;
    logic [FT_ADDR_WIDTH-1:0] addr;
    logic [FT_DATA_WIDTH-1:0] data;
    logic                     pv;
    logic [FT_PC_WIDTH-1:0]   pc;
  } ckpt_entry_t;

endpackage

// File: rtl/shadow_ckpt_rf_commit_delay_line.sv
// commit_delay_line: fixed-depth shift pipeline carrying a payload plus a
// small vector of per-entry valid bits.
//   clk_i, rst_ni : clock, synchronous active-low reset (clears valid bits)
//   flush_i       : clears every stage's valid bits at this edge; the
//                   entry presented on in_* is dropped as well
//   in_vld_i/in_data_i     : entry loaded into stage 0 every cycle
//   exit_vld_o/exit_data_o : content of the last stage (the entry that
//                            leaves the line at the next edge)
//   any_vld_o     : OR of every valid bit in every stage
module commit_delay_line #(
  parameter int DEPTH     = 2,
  parameter int VLD_W     = 2,
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic [VLD_W-1:0]     in_vld_i,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  output logic [VLD_W-1:0]     exit_vld_o,
  output logic [PAYLOAD_W-1:0] exit_data_o,
  output logic                 any_vld_o
);

  logic [VLD_W-1:0]     vld_q [DEPTH];
  logic [PAYLOAD_W-1:0] dat_q [DEPTH];

  // Control: valid bits are the only state that reset and flush touch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        vld_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= in_vld_i;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  // Data: free-running shift; meaningless whenever the matching valid is low.
  always_ff @(posedge clk_i) begin
    dat_q[0] <= in_data_i;
    for (int k = 1; k < DEPTH; k++) begin
      dat_q[k] <= dat_q[k-1];
    end
  end

  // Exit port
  assign exit_vld_o  = vld_q[DEPTH-1];
  assign exit_data_o = dat_q[DEPTH-1];

  always_comb begin
    any_vld_o = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      any_vld_o = any_vld_o | (|vld_q[k]);
    end
  end

endmodule

// File: rtl/shadow_ckpt_rf.sv
// shadow_ckpt_rf: checkpoint copy of the GPR file and committed PC.
// Writeback and retire events are held in a flushable delay line that spans
// the error-detection latency; only entries that leave the line with no error
// flagged are committed. The recovery controller reads the committed image.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   wb_we_i/addr/data  : snooped GPR writeback port
//   pc_valid_i, pc_i   : retire strobe and next-PC of the retiring instruction
//   error_i            : error flag; flushes every in-flight entry
//   replay_active_i    : recovery in progress; no new capture
//   replay_addr_i      : committed GPR index to read back
//   replay_data_o      : committed GPR[replay_addr_i] (combinational)
//   spc_o              : committed checkpoint PC (registered)
//   pending_o          : any valid entry still in flight
// The width parameters must match the ft_pkg widths, since the in-flight
// entry type comes from the package.
module shadow_ckpt_rf
  import ft_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = FT_ADDR_WIDTH,
  parameter int                    DATA_WIDTH   = FT_DATA_WIDTH,
  parameter int                    PC_WIDTH     = FT_PC_WIDTH,
  parameter int                    COMMIT_DELAY = 2,
  parameter logic [PC_WIDTH-1:0]   BOOT_ADDR    = BOOT_ADDR_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  pc_valid_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  input  logic                  error_i,
  input  logic                  replay_active_i,
  input  logic [ADDR_WIDTH-1:0] replay_addr_i,
  output logic [DATA_WIDTH-1:0] replay_data_o,
  output logic [PC_WIDTH-1:0]   spc_o,
  output logic                  pending_o
);

  localparam int PAY_W = ADDR_WIDTH + DATA_WIDTH + PC_WIDTH;

  ckpt_entry_t           cap_p0;
  ckpt_entry_t           ext_pn;
  logic [1:0]            ext_vld;
  logic [PAY_W-1:0]      ext_dat;
  logic                  commit_gv;
  logic                  commit_pv;
  logic [DATA_WIDTH-1:0] gpr_q [NUM_REG];
  logic [PC_WIDTH-1:0]   spc_q;

  // Capture: x0 writes, errored cycles and replay cycles never enter the line.
  always_comb begin
    cap_p0.gv   = wb_we_i & (wb_addr_i != '0) & ~error_i & ~replay_active_i;
    cap_p0.addr = wb_addr_i;
    cap_p0.data = wb_data_i;
    cap_p0.pv   = pc_valid_i & ~error_i & ~replay_active_i;
    cap_p0.pc   = pc_i;
  end

  commit_delay_line #(
    .DEPTH     (COMMIT_DELAY),
    .VLD_W     (2),
    .PAYLOAD_W (PAY_W)
  ) u_delay (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (error_i),
    .in_vld_i    ({cap_p0.gv, cap_p0.pv}),
    .in_data_i   ({cap_p0.addr, cap_p0.data, cap_p0.pc}),
    .exit_vld_o  (ext_vld),
    .exit_data_o (ext_dat),
    .any_vld_o   (pending_o)
  );

  // Commit: the exiting entry is dropped if an error is flagged on its way out.
  always_comb begin
    {ext_pn.gv, ext_pn.pv}                = ext_vld;
    {ext_pn.addr, ext_pn.data, ext_pn.pc} = ext_dat;
  end

  assign commit_gv = ext_pn.gv & ~error_i;
  assign commit_pv = ext_pn.pv & ~error_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_REG; r++) begin
        gpr_q[r] <= '0;
      end
    end else if (commit_gv) begin
      gpr_q[ext_pn.addr] <= ext_pn.data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      spc_q <= BOOT_ADDR;
    end else if (commit_pv) begin
      spc_q <= ext_pn.pc;
    end
  end

  // Read-back sees only the committed image, never in-flight entries.
  assign replay_data_o = gpr_q[replay_addr_i];
  assign spc_o         = spc_q;

endmodule

// File: tb/tb_shadow_ckpt_rf.sv
module tb_shadow_ckpt_rf;

  localparam int          AW   = 5;
  localparam int          DW   = 32;
  localparam int          PW   = 32;
  localparam int          CD   = 2;
  localparam logic [31:0] BOOT = 32'h0000_0080;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          wb_we_i;
  logic [AW-1:0] wb_addr_i;
  logic [DW-1:0] wb_data_i;
  logic          pc_valid_i;
  logic [PW-1:0] pc_i;
  logic          error_i;
  logic          replay_active_i;
  logic [AW-1:0] replay_addr_i;
  logic [DW-1:0] replay_data_o;
  logic [PW-1:0] spc_o;
  logic          pending_o;

  always #5 clk_i = ~clk_i;

  shadow_ckpt_rf #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .PC_WIDTH     (PW),
    .COMMIT_DELAY (CD),
    .BOOT_ADDR    (BOOT)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .wb_we_i         (wb_we_i),
    .wb_addr_i       (wb_addr_i),
    .wb_data_i       (wb_data_i),
    .pc_valid_i      (pc_valid_i),
    .pc_i            (pc_i),
    .error_i         (error_i),
    .replay_active_i (replay_active_i),
    .replay_addr_i   (replay_addr_i),
    .replay_data_o   (replay_data_o),
    .spc_o           (spc_o),
    .pending_o       (pending_o)
  );

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef enum {K_GPR, K_SPC, K_PEND} kind_e;
  typedef struct {
    int          due;
    string       tag;
    kind_e       kind;
    logic [4:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_at(input int due, input string tag, input kind_e kind,
                           input logic [4:0] addr, input logic [31:0] val);
    exp_t e;
    e.due  = due;
    e.tag  = tag;
    e.kind = kind;
    e.addr = addr;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic read_gpr(input logic [4:0] a, output logic [31:0] d);
    replay_addr_i = a;
    #1;
    d = replay_data_o;
  endtask

  task automatic score();
    logic [31:0] d;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          K_GPR: begin
            read_gpr(sb[i].addr, d);
            chk(sb[i].tag, d, sb[i].val);
          end
          K_SPC:   chk(sb[i].tag, spc_o, sb[i].val);
          default: chk(sb[i].tag, {31'b0, pending_o}, sb[i].val);
        endcase
        sb.delete(i);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    score();
  endtask

  task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d,
                       input logic pv, input logic [31:0] pc, input logic err,
                       input logic rep);
    wb_we_i         = we;
    wb_addr_i       = a;
    wb_data_i       = d;
    pc_valid_i      = pv;
    pc_i            = pc;
    error_i         = err;
    replay_active_i = rep;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d checks outstanding", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int          t;
    int          guard;
    logic [31:0] d;

    rst_ni        = 1'b0;
    replay_addr_i = '0;
    idle();
    tick();
    tick();
    rst_ni = 1'b1;

    // 1: reset image
    for (int a = 0; a < 32; a++) begin
      read_gpr(a[4:0], d);
      chk($sformatf("rst_gpr%0d", a), d, 32'd0);
    end
    chk("rst_spc", spc_o, BOOT);
    chk("rst_pend", {31'b0, pending_o}, 32'd0);
    tick();

    // 2: basic commit latency
    t = cyc + 1;
    expect_at(t,     "t2_x5_e0",   K_GPR,  5, 32'd0);
    expect_at(t + 1, "t2_x5_e1",   K_GPR,  5, 32'd0);
    expect_at(t + 2, "t2_x5_e2",   K_GPR,  5, 32'hDEAD_BEEF);
    expect_at(t + 1, "t2_spc_e1",  K_SPC,  0, BOOT);
    expect_at(t + 2, "t2_spc_e2",  K_SPC,  0, 32'h104);
    expect_at(t,     "t2_pend_e0", K_PEND, 0, 32'd1);
    expect_at(t + 2, "t2_pend_e2", K_PEND, 0, 32'd0);
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 32'h104, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    tick();

    // 3a: committed x7=0x22
    t = cyc + 1;
    expect_at(t + 2, "t3_x7_pre", K_GPR, 7, 32'h22);
    drive(1'b1, 5'd7, 32'h22, 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    tick();

    // 3b: error one cycle after write, held two cycles, with a write presented
    t = cyc + 1;
    expect_at(t,     "t3_pend_e0",  K_PEND, 0, 32'd1);
    expect_at(t + 1, "t3_pend_e1",  K_PEND, 0, 32'd0);
    expect_at(t + 1, "t3_x7_e1",    K_GPR,  7, 32'h22);
    expect_at(t + 2, "t3_x7_e2",    K_GPR,  7, 32'h22);
    expect_at(t + 3, "t3_x7_e3",    K_GPR,  7, 32'h22);
    expect_at(t + 3, "t3_spc_e3",   K_SPC,  0, 32'h104);
    expect_at(t + 4, "t3_x7_e4",    K_GPR,  7, 32'h22);
    expect_at(t + 4, "t3_spc_e4",   K_SPC,  0, 32'h104);
    drive(1'b1, 5'd7, 32'h11, 1'b1, 32'h200, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 32'h33, 1'b1, 32'h300, 1'b1, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    tick();

    // 3c: error on the cycle the entry exits
    t = cyc + 1;
    expect_at(t + 1, "t3c_pend_e1", K_PEND, 0, 32'd1);
    expect_at(t + 2, "t3c_x8_e2",   K_GPR,  8, 32'd0);
    expect_at(t + 2, "t3c_pend_e2", K_PEND, 0, 32'd0);
    expect_at(t + 3, "t3c_x8_e3",   K_GPR,  8, 32'd0);
    expect_at(t + 3, "t3c_spc_e3",  K_SPC,  0, 32'h104);
    drive(1'b1, 5'd8, 32'h55, 1'b1, 32'h500, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    idle();
    tick();

    // 4: back-to-back same index, then x0 write
    t = cyc + 1;
    expect_at(t + 2, "t4_x3_e2",   K_GPR,  3, 32'd1);
    expect_at(t + 3, "t4_x3_e3",   K_GPR,  3, 32'd2);
    expect_at(t + 3, "t4_pend_e3", K_PEND, 0, 32'd1);
    expect_at(t + 4, "t4_x3_e4",   K_GPR,  3, 32'd3);
    expect_at(t + 4, "t4_pend_e4", K_PEND, 0, 32'd0);
    expect_at(t + 5, "t4_x0_e5",   K_GPR,  0, 32'd0);
    expect_at(t + 6, "t4_x3_e6",   K_GPR,  3, 32'd3);
    drive(1'b1, 5'd3, 32'd1, 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 32'd2, 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 32'd3, 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    tick();
    tick();

    // 5: replay freezes capture, in-flight write still commits
    t = cyc + 1;
    expect_at(t,     "t5_pend_e0", K_PEND, 0,  32'd1);
    expect_at(t + 2, "t5_x10_e2",  K_GPR,  10, 32'h77);
    expect_at(t + 2, "t5_spc_e2",  K_SPC,  0,  32'h600);
    expect_at(t + 2, "t5_pend_e2", K_PEND, 0,  32'd0);
    expect_at(t + 3, "t5_x9_e3",   K_GPR,  9,  32'd0);
    expect_at(t + 4, "t5_x9_e4",   K_GPR,  9,  32'd0);
    expect_at(t + 5, "t5_x9_e5",   K_GPR,  9,  32'd0);
    expect_at(t + 5, "t5_spc_e5",  K_SPC,  0,  32'h600);
    drive(1'b1, 5'd10, 32'h77, 1'b1, 32'h600, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd9, 32'hAA, 1'b1, 32'h700, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    idle();
    tick();
    tick();

    // 6: reset mid-flight, then capture resumes
    t = cyc + 1;
    expect_at(t + 1, "t6_x4_e1",   K_GPR,  4,  32'd0);
    expect_at(t + 1, "t6_x5_e1",   K_GPR,  5,  32'd0);
    expect_at(t + 1, "t6_x10_e1",  K_GPR,  10, 32'd0);
    expect_at(t + 1, "t6_pend_e1", K_PEND, 0,  32'd0);
    expect_at(t + 1, "t6_spc_e1",  K_SPC,  0,  BOOT);
    expect_at(t + 2, "t6_x4_e2",   K_GPR,  4,  32'd0);
    expect_at(t + 2, "t6_spc_e2",  K_SPC,  0,  BOOT);
    expect_at(t + 4, "t6_x4_e4",   K_GPR,  4,  32'h66);
    expect_at(t + 4, "t6_spc_e4",  K_SPC,  0,  32'h900);
    drive(1'b1, 5'd4, 32'h44, 1'b1, 32'h800, 1'b0, 1'b0);
    tick();
    rst_ni = 1'b0;
    idle();
    tick();
    rst_ni = 1'b1;
    drive(1'b1, 5'd4, 32'h66, 1'b1, 32'h900, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    tick();

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      tick();
      guard++;
    end
    while (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: not checked by cycle %0d (due %0d)", sb[0].tag, cyc, sb[0].due);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
